vm_order_ctrl: RTL

- Parametrised successor to the vending-machine mode controller.
- Fully synchronous mode FSM driven by one-cold front-panel switches; item cursor and quantity counters with wrap and saturation; saturating cart accumulator with sticky overflow; registered, edge-detected switch decoding.
- Sits between panel input conditioning (debounced step strobes) and the display/price-dictionary blocks.
- Price lookup stays external: cursor out, price in.

---
 rtl/vm_pkg.sv | 28 ++
 rtl/vm_sw_press.sv | 42 ++++
 rtl/vm_order_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine order controller.
// Holds the mode encoding (also the value driven on the mode output) and
// the active-low one-cold front-panel switch codes.
package vm_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'b000,
        MODE_SELECT = 3'b001,
        MODE_QTY    = 3'b010,
        MODE_ADD    = 3'b011,
        MODE_LOCK   = 3'b100
    } mode_e;

    localparam logic [3:0] SW_IDLE = 4'b0111;
    localparam logic [3:0] SW_SEL  = 4'b1011;
    localparam logic [3:0] SW_QTY  = 4'b1101;
    localparam logic [3:0] SW_ADD  = 4'b1110;
    localparam logic [3:0] SW_NONE = 4'b1111;

    // One decoded key press; at most one field is set in any cycle.
    typedef struct packed {
        logic idle;
        logic sel;
        logic qty;
        logic add;
    } press_t;

endpackage

// File: rtl/vm_sw_press.sv
// Front-panel switch conditioning: two-flop synchroniser, history register
// and press decoder.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   switches           raw active-low one-cold keys, asynchronous to clk
//   press_idle/sel/qty/add  one-cycle pulses, one per accepted key press
module vm_sw_press
    import vm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] switches,
    output logic       press_idle,
    output logic       press_sel,
    output logic       press_qty,
    output logic       press_add
);

    logic [3:0] sync1_q, sync2_q, hist_q;
    logic       armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SW_NONE;
            sync2_q <= SW_NONE;
            hist_q  <= SW_NONE;
        end else begin
            sync1_q <= switches;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // A press counts only on the first cycle of a legal code that follows a
    // full release; held keys and key-to-key slides never re-arm.
    assign armed      = (hist_q == SW_NONE);
    assign press_idle = armed && (sync2_q == SW_IDLE);
    assign press_sel  = armed && (sync2_q == SW_SEL);
    assign press_qty  = armed && (sync2_q == SW_QTY);
    assign press_add  = armed && (sync2_q == SW_ADD);

endmodule

// File: rtl/vm_order_ctrl.sv
// Vending-machine order controller: mode FSM, item cursor, quantity counter
// and saturating cart accumulator. Price lookup is external (cn_now out,
// item_price back in the same cycle).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   switches              raw active-low one-cold mode keys
//   fix                   lock request, taken with an ADD key press
//   sel_up/sel_dn         cursor step strobes (SELECT only)
//   qty_up/qty_dn         quantity step strobes (QTY only)
//   item_price            price of cn_now
//   cn_now, qty_now       cursor and quantity
//   total_sum, sum_ovf    cart total and sticky saturation flag
//   mode                  FSM state
//   add_ack               high for the single ADD cycle
module vm_order_ctrl
    import vm_pkg::*;
#(
    parameter int N_ITEMS = 1024,
    parameter int QTY_W   = 7,
    parameter int QTY_MAX = 99,
    parameter int PRICE_W = 17,
    parameter int SUM_W   = 17,
    localparam int CN_W   = $clog2(N_ITEMS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         switches,
    input  logic               fix,
    input  logic               sel_up,
    input  logic               sel_dn,
    input  logic               qty_up,
    input  logic               qty_dn,
    input  logic [PRICE_W-1:0] item_price,
    output logic [CN_W-1:0]    cn_now,
    output logic [QTY_W-1:0]   qty_now,
    output logic [SUM_W-1:0]   total_sum,
    output logic [2:0]         mode,
    output logic               sum_ovf,
    output logic               add_ack
);

    localparam int PROD_W = PRICE_W + QTY_W;
    localparam int ACC_W  = ((SUM_W > PROD_W) ? SUM_W : PROD_W) + 1;

    localparam logic [CN_W-1:0]  CN_LAST = CN_W'(N_ITEMS - 1);
    localparam logic [QTY_W-1:0] Q_MAX   = QTY_W'(QTY_MAX);
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    mode_e             mode_q, mode_d;
    logic [CN_W-1:0]   cn_q, cn_d;
    logic [QTY_W-1:0]  qty_q, qty_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              ovf_q, ovf_d;
    press_t            pend_q, pend_d;
    logic              pend_fix_q, pend_fix_d;

    press_t            live, eff;
    logic              eff_fix;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc;
    logic              acc_over;

    vm_sw_press u_sw (
        .clk        (clk),
        .rst_n      (rst_n),
        .switches   (switches),
        .press_idle (live.idle),
        .press_sel  (live.sel),
        .press_qty  (live.qty),
        .press_add  (live.add)
    );

    // Presses seen during the ADD cycle are parked and replayed next cycle.
    always_comb begin
        pend_d     = '0;
        pend_fix_d = 1'b0;
        eff        = '0;
        eff_fix    = fix;
        if (mode_q == MODE_ADD) begin
            pend_d     = live;
            pend_fix_d = fix;
        end else if (|pend_q) begin
            eff     = pend_q;
            eff_fix = pend_fix_q;
        end else begin
            eff = live;
        end
    end

    assign prod     = PROD_W'(item_price) * PROD_W'(qty_q);
    assign acc      = ACC_W'(sum_q) + ACC_W'(prod);
    assign acc_over = (acc > ACC_W'(SUM_MAX));

    always_comb begin
        mode_d = mode_q;
        cn_d   = cn_q;
        qty_d  = qty_q;
        sum_d  = sum_q;
        ovf_d  = ovf_q;

        unique case (mode_q)
            MODE_LOCK: begin
                if (eff.idle) mode_d = MODE_IDLE;
            end
            MODE_ADD: begin
                mode_d = MODE_QTY;
                qty_d  = '0;
                if (acc_over) begin
                    sum_d = SUM_MAX;
                    ovf_d = 1'b1;
                end else begin
                    sum_d = acc[SUM_W-1:0];
                end
            end
            default: begin
                if (eff.idle)      mode_d = MODE_IDLE;
                else if (eff.sel)  mode_d = MODE_SELECT;
                else if (eff.qty)  mode_d = MODE_QTY;
                else if (eff.add)  mode_d = eff_fix ? MODE_LOCK : MODE_ADD;

                if (mode_q == MODE_IDLE) begin
                    cn_d  = '0;
                    qty_d = '0;
                    sum_d = '0;
                    ovf_d = 1'b0;
                end

                if (mode_q == MODE_SELECT && (sel_up ^ sel_dn)) begin
                    if (sel_up) cn_d = (cn_q == CN_LAST) ? '0 : cn_q + 1'b1;
                    else        cn_d = (cn_q == '0) ? CN_LAST : cn_q - 1'b1;
                end

                if (mode_q == MODE_QTY && (qty_up ^ qty_dn)) begin
                    if (qty_up) qty_d = (qty_q >= Q_MAX) ? Q_MAX : qty_q + 1'b1;
                    else        qty_d = (qty_q == '0) ? '0 : qty_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_IDLE;
            cn_q       <= '0;
            qty_q      <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            pend_q     <= '0;
            pend_fix_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            cn_q       <= cn_d;
            qty_q      <= qty_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
            pend_fix_q <= pend_fix_d;
        end
    end

    assign cn_now    = cn_q;
    assign qty_now   = qty_q;
    assign total_sum = sum_q;
    assign sum_ovf   = ovf_q;
    assign mode      = mode_q;
    assign add_ack   = (mode_q == MODE_ADD);

endmodule
